// File: rtl/mandel_iter_ctrl.sv
// Mandelbrot iteration sequencer for one pixel: drives a shared serial multiplier
// through zr*zr, zi*zi, zr*zi per iteration, then checks escape and updates z.
module mandel_iter_ctrl #(
    parameter int WIDTH    = 10,
    parameter int FRAC     = 7,
    parameter int MAX_ITER = 15,
    localparam int ITER_W  = $clog2(MAX_ITER + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic signed [WIDTH-1:0]   cr,
    input  logic signed [WIDTH-1:0]   ci,
    output logic                      busy,
    output logic                      done,
    output logic [ITER_W-1:0]         iter_count,
    output logic                      escaped,
    output logic signed [WIDTH-1:0]   mul_x,
    output logic signed [WIDTH-1:0]   mul_y,
    output logic                      mul_start,
    input  logic signed [2*WIDTH-1:0] mul_out,
    input  logic                      mul_finished
);

    localparam int PW = 2 * WIDTH - FRAC;
    localparam int GW = PW + 2;
    localparam logic signed [PW:0]   ESC_LIMIT = (PW + 1)'(4 << FRAC);
    localparam logic signed [GW-1:0] Z_MAX     = GW'((1 << (WIDTH - 1)) - 1);
    localparam logic signed [GW-1:0] Z_MIN     = -GW'(1 << (WIDTH - 1));

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        ARM,
        WAIT,
        UPDATE,
        DONE
    } state_t;

    typedef enum logic [1:0] {
        OP_XX,
        OP_YY,
        OP_XY
    } op_t;

    state_t state, state_next;
    op_t    op;

    logic signed [WIDTH-1:0] zr, zi, cr_q, ci_q;
    logic signed [PW-1:0]    xx, yy, xy, prod;
    logic signed [PW:0]      mag;
    logic signed [GW-1:0]    re_w, im_w;
    logic [ITER_W-1:0]       iter_inc;
    logic                    esc_hit, last_iter;

    function automatic logic signed [WIDTH-1:0] sat(input logic signed [GW-1:0] v);
        if (v > Z_MAX)
            return WIDTH'(Z_MAX);
        else if (v < Z_MIN)
            return WIDTH'(Z_MIN);
        else
            return WIDTH'(v);
    endfunction

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_next;
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start) state_next = ISSUE;
            ISSUE:   if (mul_finished) state_next = ARM;
            ARM:     state_next = WAIT;
            WAIT: begin
                if (mul_finished)
                    state_next = (op == OP_XY) ? UPDATE : ISSUE;
            end
            UPDATE:  state_next = (esc_hit || last_iter) ? DONE : ISSUE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy      = (state != IDLE) && (state != DONE);
        done      = (state == DONE);
        mul_start = (state == ISSUE) && mul_finished;
    end

    // Operands come straight from op/z, which only change at capture or update,
    // so they stay stable for the whole multiply.
    always_comb begin
        unique case (op)
            OP_XX: begin
                mul_x = zr;
                mul_y = zr;
            end
            OP_YY: begin
                mul_x = zi;
                mul_y = zi;
            end
            default: begin
                mul_x = zr;
                mul_y = zi;
            end
        endcase
    end

    always_comb begin
        prod      = PW'(mul_out >>> FRAC);
        mag       = (PW + 1)'(xx) + (PW + 1)'(yy);
        esc_hit   = mag > ESC_LIMIT;
        re_w      = GW'(xx) - GW'(yy) + GW'(cr_q);
        im_w      = (GW'(xy) <<< 1) + GW'(ci_q);
        iter_inc  = iter_count + ITER_W'(1);
        last_iter = (iter_inc == ITER_W'(MAX_ITER));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op         <= OP_XX;
            zr         <= '0;
            zi         <= '0;
            cr_q       <= '0;
            ci_q       <= '0;
            xx         <= '0;
            yy         <= '0;
            xy         <= '0;
            iter_count <= '0;
            escaped    <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        cr_q       <= cr;
                        ci_q       <= ci;
                        zr         <= '0;
                        zi         <= '0;
                        iter_count <= '0;
                        escaped    <= 1'b0;
                        op         <= OP_XX;
                    end
                end
                WAIT: begin
                    if (mul_finished) begin
                        unique case (op)
                            OP_XX: begin
                                xx <= prod;
                                op <= OP_YY;
                            end
                            OP_YY: begin
                                yy <= prod;
                                op <= OP_XY;
                            end
                            default: xy <= prod;
                        endcase
                    end
                end
                UPDATE: begin
                    if (esc_hit) begin
                        escaped <= 1'b1;
                    end else begin
                        zr         <= sat(re_w);
                        zi         <= sat(im_w);
                        iter_count <= iter_inc;
                        op         <= OP_XX;
                        if (last_iter)
                            escaped <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mandel_iter_ctrl.sv
// Scoreboard bench for mandel_iter_ctrl with a serial multiplier model that
// takes LOCAL+2 cycles per product and keeps running across controller resets.
module tb_mandel_iter_ctrl;

    localparam int WIDTH    = 10;
    localparam int FRAC     = 7;
    localparam int MAX_ITER = 15;
    localparam int ITER_W   = $clog2(MAX_ITER + 1);
    localparam int LOCAL    = (WIDTH + 1) / 2;
    localparam int ITER_CYC = 3 * (LOCAL + 2) + 1;

    logic                      clk = 1'b0;
    logic                      rst, start;
    logic signed [WIDTH-1:0]   cr, ci;
    logic                      busy, done, escaped, mul_start, mul_finished;
    logic [ITER_W-1:0]         iter_count;
    logic signed [WIDTH-1:0]   mul_x, mul_y;
    logic signed [2*WIDTH-1:0] mul_out;
    logic                      stall;

    always #5 clk = ~clk;

    mandel_iter_ctrl #(
        .WIDTH   (WIDTH),
        .FRAC    (FRAC),
        .MAX_ITER(MAX_ITER)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .cr          (cr),
        .ci          (ci),
        .busy        (busy),
        .done        (done),
        .iter_count  (iter_count),
        .escaped     (escaped),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_start   (mul_start),
        .mul_out     (mul_out),
        .mul_finished(mul_finished)
    );

    // Multiplier model: finished drops the cycle after start, result after LOCAL more edges.
    logic [3:0]                mcnt  = '0;
    logic signed [2*WIDTH-1:0] mprod = '0;

    always @(posedge clk) begin
        if (mcnt != 0)
            mcnt <= mcnt - 4'd1;
        else if (mul_start) begin
            mcnt  <= 4'(LOCAL);
            mprod <= mul_x * mul_y;
        end
    end

    assign mul_out      = mprod;
    assign mul_finished = (mcnt == 0) && !stall;

    typedef struct {
        int it;
        int esc;
        int ms;
        int lat;
    } exp_t;

    exp_t sb[$];

    int n_checks = 0;
    int n_pass   = 0;
    int cyc = 0, cyc_start = 0, n_mstart = 0, n_viol = 0, n_hold_viol = 0, n_done = 0;
    bit track = 1'b0;
    logic signed [WIDTH-1:0] hx, hy;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        else
            n_pass++;
    endtask

    function automatic int satz(input int v);
        if (v > 511) return 511;
        if (v < -512) return -512;
        return v;
    endfunction

    function automatic void model(input int c_r, input int c_i, output int it, output int esc);
        int zr0, zi0, xx, yy, xy;
        zr0 = 0;
        zi0 = 0;
        it  = 0;
        esc = 0;
        for (int k = 0; k < MAX_ITER; k++) begin
            xx = (zr0 * zr0) >>> FRAC;
            yy = (zi0 * zi0) >>> FRAC;
            xy = (zr0 * zi0) >>> FRAC;
            if (xx + yy > (4 << FRAC)) begin
                esc = 1;
                return;
            end
            zr0 = satz(xx - yy + c_r);
            zi0 = satz(2 * xy + c_i);
            it++;
        end
    endfunction

    always @(negedge clk) begin : mon
        exp_t e;
        cyc++;
        if (mul_start) n_mstart++;
        if (mul_start && !mul_finished) n_viol++;
        if (!rst && start && !busy && !done) begin
            cyc_start = cyc;
            n_mstart  = 0;
        end
        if (rst)
            track = 1'b0;
        else if (mul_start) begin
            track = 1'b1;
            hx    = mul_x;
            hy    = mul_y;
        end else if (track) begin
            if (mul_x !== hx || mul_y !== hy) n_hold_viol++;
            if (mul_finished) track = 1'b0;
        end
        if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                check("spurious_done", 32'(done), 0);
            end else begin
                e = sb.pop_front();
                check("iter_count", 32'(iter_count), e.it);
                check("escaped", 32'(escaped), e.esc);
                check("mul_starts", n_mstart, e.ms);
                if (e.lat >= 0)
                    check("latency", cyc - cyc_start + 1, e.lat);
            end
        end
    end

    task automatic push_pixel(input int c_r, input int c_i, input int extra, input bit skip_lat);
        exp_t e;
        int it, esc, k;
        model(c_r, c_i, it, esc);
        k     = esc ? it + 1 : it;
        e.it  = it;
        e.esc = esc;
        e.ms  = 3 * k;
        e.lat = skip_lat ? -1 : ITER_CYC * k + 2 + extra;
        sb.push_back(e);
    endtask

    task automatic drive_start(input int c_r, input int c_i);
        @(posedge clk);
        #2;
        cr    = WIDTH'(c_r);
        ci    = WIDTH'(c_i);
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
    endtask

    task automatic wait_idle();
        for (int n = 0; n < 3000 && (busy || done); n++) begin
            @(posedge clk);
            #1;
        end
        if (busy || done) check("idle_timeout", 32'(busy | done), 0);
    endtask

    task automatic wait_done();
        int target;
        target = n_done + 1;
        for (int n = 0; n < 3000 && n_done < target; n++) @(posedge clk);
        if (n_done < target) begin
            check("done_timeout", n_done, target);
            sb.delete();
        end
    endtask

    task automatic run_pixel(input int c_r, input int c_i);
        wait_idle();
        push_pixel(c_r, c_i, 0, 1'b0);
        drive_start(c_r, c_i);
        wait_done();
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        stall = 1'b0;
        cr    = '0;
        ci    = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_iter", 32'(iter_count), 0);
        check("rst_escaped", 32'(escaped), 0);
        check("rst_mul_start", 32'(mul_start), 0);
        check("rst_mul_x", 32'(mul_x), 0);
        check("rst_mul_y", 32'(mul_y), 0);
        rst = 1'b0;

        run_pixel(0, 0);
        run_pixel(256, 0);
        run_pixel(-256, 0);
        run_pixel(0, 128);
        run_pixel(128, 0);
        for (int i = 0; i < 6; i++)
            run_pixel(int'($urandom_range(600)) - 300, int'($urandom_range(600)) - 300);

        // start while busy is ignored
        wait_idle();
        push_pixel(0, 0, 0, 1'b0);
        drive_start(0, 0);
        repeat (20) @(posedge clk);
        #2;
        cr    = 10'sd128;
        start = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        start = 1'b0;
        wait_done();

        // start during the DONE cycle is ignored
        wait_idle();
        push_pixel(-256, 0, 0, 1'b0);
        drive_start(-256, 0);
        for (int n = 0; n < 3000 && !done; n++) begin
            @(posedge clk);
            #1;
        end
        if (!done) check("done_wait", 32'(done), 1);
        #1;
        cr    = 10'sd0;
        ci    = 10'sd128;
        start = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check("done_start_busy", 32'(busy), 0);
        end
        check("hold_iter", 32'(iter_count), MAX_ITER);
        check("hold_escaped", 32'(escaped), 0);

        // multiplier reports not-finished for 5 cycles in ISSUE
        wait_idle();
        push_pixel(128, 0, 5, 1'b0);
        @(posedge clk);
        #2;
        cr    = 10'sd128;
        ci    = 10'sd0;
        start = 1'b1;
        stall = 1'b1;
        @(posedge clk);
        #2;
        start = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("stall_mstart", n_mstart, 0);
        check("stall_busy", 32'(busy), 1);
        #1;
        stall = 1'b0;
        wait_done();

        // reset during the first WAIT of the 3rd iteration
        wait_idle();
        push_pixel(0, 0, 0, 1'b0);
        drive_start(0, 0);
        for (int n = 0; n < 3000 && n_mstart < 7; n++) begin
            @(posedge clk);
            #1;
        end
        check("abort_reach", n_mstart, 7);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        sb.delete();
        check("abort_busy", 32'(busy), 0);
        check("abort_done", 32'(done), 0);
        check("abort_iter", 32'(iter_count), 0);
        check("abort_escaped", 32'(escaped), 0);
        push_pixel(0, 0, 0, 1'b1);
        drive_start(0, 0);
        wait_done();

        repeat (5) @(posedge clk);
        #1;
        check("mstart_when_busy", n_viol, 0);
        check("operand_hold", n_hold_viol, 0);
        check("sb_empty", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
